fu_ctx_seq: RTL and testbench

- Per-PE context sequencer sitting directly upstream of the functional unit (fu).
- Holds a small register-file of configuration contexts, loaded through a valid/ready port.
- On start, replays contexts 0..last, one per clock, for a programmed number of iterations.
- Drives the fu's en/op inputs plus operand-mux selects and an immediate every cycle.

---
 rtl/fu_ctx_seq.sv | 155 +++++++++++++++
 tb/tb_fu_ctx_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_ctx_seq.sv
// fu_ctx_seq: per-PE context sequencer feeding the functional unit.
// Holds NUM_CTX configuration contexts. After start it replays contexts
// 0..last, one per clock, for a programmed number of iterations. It drives
// the fu enable/opcode, the operand-mux selects and an immediate.
//
// State | Meaning
// IDLE  | accepting context writes and waiting for start; data outputs held at 0
// RUN   | replaying context slot pc on the outputs every cycle
// DONE  | one-cycle completion pulse on done; data outputs 0
//
// Ports:
//   clk, rst (async, active-low)
//   cfg_valid/cfg_ready/cfg_addr/cfg_data : context write port (IDLE only)
//   start, stop, cfg_last, cfg_iters      : run control (last/iters latched at start)
//   fu_en, fu_op, sel_a, sel_b, imm       : registered fu controls
//   busy, done                            : run status
module fu_ctx_seq #(
    parameter int NUM_CTX = 8,
    parameter int CTX_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CTX_W-1:0] cfg_addr,
    input  logic [24:0]      cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic [CTX_W-1:0] cfg_last,
    input  logic [15:0]      cfg_iters,
    output logic             fu_en,
    output logic [3:0]       fu_op,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic [15:0]      imm,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [24:0]      ctx_mem [NUM_CTX];
    logic [CTX_W-1:0] pc, pc_nx;
    logic [CTX_W-1:0] last_q, last_nx;
    logic [15:0]      iter, iter_nx;
    logic [15:0]      iters_q, iters_nx;
    logic             wr_en;
    logic [24:0]      rd_data;

    assign wr_en = cfg_valid && (state == S_IDLE);

    // A write landing on the same edge as start must already be visible in
    // the first RUN cycle, so bypass it past the array read.
    assign rd_data = (wr_en && (cfg_addr == pc_nx)) ? cfg_data : ctx_mem[pc_nx];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        iter_nx  = iter;
        last_nx  = last_q;
        iters_nx = iters_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                    pc_nx    = '0;
                    iter_nx  = 16'd1;
                    last_nx  = cfg_last;
                    iters_nx = cfg_iters;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nx = S_IDLE;
                    pc_nx    = '0;
                    iter_nx  = '0;
                end else if (pc != last_q) begin
                    pc_nx = pc + 1'b1;
                end else if ((iters_q == 16'd0) || (iter < iters_q)) begin
                    // iters == 0 runs until stop; iter is allowed to wrap
                    pc_nx   = '0;
                    iter_nx = iter + 16'd1;
                end else begin
                    state_nx = S_DONE;
                    pc_nx    = '0;
                    iter_nx  = '0;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                pc_nx    = '0;
                iter_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            iter    <= '0;
            last_q  <= '0;
            iters_q <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            iter    <= iter_nx;
            last_q  <= last_nx;
            iters_q <= iters_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CTX; i++) begin
                ctx_mem[i] <= '0;
            end
        end else if (wr_en) begin
            ctx_mem[cfg_addr] <= cfg_data;
        end
    end

    // Outputs are registered from the next state so the slot shown during a
    // RUN cycle is the one pc points at in that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            fu_en     <= 1'b0;
            fu_op     <= '0;
            sel_a     <= '0;
            sel_b     <= '0;
            imm       <= '0;
        end else begin
            cfg_ready <= (state_nx == S_IDLE);
            busy      <= (state_nx == S_RUN);
            done      <= (state_nx == S_DONE);
            if (state_nx == S_RUN) begin
                {fu_en, fu_op, sel_a, sel_b, imm} <= rd_data;
            end else begin
                {fu_en, fu_op, sel_a, sel_b, imm} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fu_ctx_seq.sv
module tb_fu_ctx_seq;

    typedef struct packed {
        logic [24:0] d;
        logic        busy;
        logic        done;
        logic        ready;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [24:0] cfg_data;
    logic        start;
    logic        stop;
    logic [2:0]  cfg_last;
    logic [15:0] cfg_iters;
    logic        fu_en;
    logic [3:0]  fu_op;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [15:0] imm;
    logic        busy;
    logic        done;

    int          total;
    int          bad;
    logic        mon_on;
    int          cyc_id;
    exp_t        sb_q[$];
    logic [24:0] ctx_m [8];

    fu_ctx_seq #(.NUM_CTX(8), .CTX_W(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .stop(stop),
        .cfg_last(cfg_last), .cfg_iters(cfg_iters),
        .fu_en(fu_en), .fu_op(fu_op), .sel_a(sel_a), .sel_b(sel_b), .imm(imm),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [24:0] mk(input logic en, input logic [3:0] op,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [15:0] im);
        return {en, op, a, b, im};
    endfunction

    // Scoreboard monitor: one expectation consumed per cycle, mid-cycle.
    always @(negedge clk) begin
        if (mon_on && sb_q.size() > 0) begin
            exp_t e;
            exp_t o;
            e = sb_q.pop_front();
            o = {fu_en, fu_op, sel_a, sel_b, imm, busy, done, cfg_ready};
            total++;
            cyc_id++;
            if (o !== e) begin
                bad++;
                $display("FAIL sb_cycle%0d got d=%h busy=%b done=%b ready=%b exp d=%h busy=%b done=%b ready=%b",
                         cyc_id, o.d, o.busy, o.done, o.ready, e.d, e.busy, e.done, e.ready);
            end
        end
    end

    // Called at posedge+1. Pushes the expected trace, then presents start for one edge.
    // n_stop > 0 means stop will be asserted after n_stop RUN cycles.
    task automatic start_prog(input logic [2:0] last, input logic [15:0] iters, input int n_stop,
                              input logic wr, input logic [2:0] wa, input logic [24:0] wd);
        int pc;
        int it;
        int n;
        if (wr) ctx_m[wa] = wd;
        pc = 0;
        it = 1;
        n  = 0;
        while (n < 500) begin
            sb_q.push_back('{d: ctx_m[pc], busy: 1'b1, done: 1'b0, ready: 1'b0});
            n++;
            if (n_stop > 0 && n == n_stop) break;
            if (pc != int'(last)) begin
                pc++;
            end else if (iters == 16'd0 || it < int'(iters)) begin
                pc = 0;
                it++;
            end else begin
                sb_q.push_back('{d: 25'd0, busy: 1'b0, done: 1'b1, ready: 1'b0});
                break;
            end
        end
        sb_q.push_back('{d: 25'd0, busy: 1'b0, done: 1'b0, ready: 1'b1});
        cfg_last  = last;
        cfg_iters = iters;
        cfg_valid = wr;
        cfg_addr  = wa;
        cfg_data  = wd;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 3'd7;
        cfg_iters = 16'd5;
        mon_on    = 1'b1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            if (sb_q.size() == 0) break;
        end
        #1;
        mon_on = 1'b0;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout left=%0d exp=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [24:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        #1;
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready);
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        ctx_m[a]  = d;
    endtask

    task automatic test_reset();
        logic [27:0] o;
        rst = 1'b0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; stop = 1'b0; cfg_last = '0; cfg_iters = '0;
        for (int i = 0; i < 8; i++) ctx_m[i] = '0;
        #12;
        o = {fu_en, fu_op, sel_a, sel_b, imm, busy, done, cfg_ready};
        total++;
        if (o !== {25'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", o, {25'd0, 3'b001});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_pass();
        cfg_write(3'd0, mk(1'b1, 4'd2, 2'd0, 2'd1, 16'h0005));
        cfg_write(3'd1, mk(1'b1, 4'd3, 2'd1, 2'd0, 16'h0001));
        cfg_write(3'd2, mk(1'b1, 4'd0, 2'd2, 2'd2, 16'hFFFF));
        start_prog(3'd2, 16'd1, 0, 1'b0, 3'd0, 25'd0);
        wait_drain();
    endtask

    task automatic test_iters3();
        start_prog(3'd2, 16'd3, 0, 1'b0, 3'd0, 25'd0);
        wait_drain();
    endtask

    task automatic test_free_run_stop();
        start_prog(3'd1, 16'd0, 7, 1'b0, 3'd0, 25'd0);
        repeat (6) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_drain();
    endtask

    task automatic test_cfg_while_busy();
        start_prog(3'd2, 16'd3, 0, 1'b0, 3'd0, 25'd0);
        cfg_valid = 1'b1;
        cfg_addr  = 3'd0;
        cfg_data  = mk(1'b1, 4'hF, 2'd3, 2'd3, 16'hDEAD);
        start     = 1'b1;
        @(posedge clk);
        #2;
        total++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL ready_while_busy got ready=%b busy=%b exp ready=0 busy=1", cfg_ready, busy);
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        wait_drain();
        start_prog(3'd2, 16'd1, 0, 1'b0, 3'd0, 25'd0);
        wait_drain();
    endtask

    task automatic test_cfg_with_start();
        start_prog(3'd2, 16'd1, 0, 1'b1, 3'd1, mk(1'b1, 4'd7, 2'd1, 2'd1, 16'hBEEF));
        wait_drain();
        start_prog(3'd1, 16'd1, 0, 1'b1, 3'd0, mk(1'b1, 4'd5, 2'd2, 2'd1, 16'h0A0A));
        wait_drain();
    endtask

    task automatic test_en_zero();
        cfg_write(3'd3, mk(1'b0, 4'd4, 2'd1, 2'd2, 16'h1234));
        start_prog(3'd3, 16'd1, 0, 1'b0, 3'd0, 25'd0);
        wait_drain();
    endtask

    task automatic test_single_ctx();
        start_prog(3'd0, 16'd3, 0, 1'b0, 3'd0, 25'd0);
        wait_drain();
    endtask

    task automatic test_reset_mid_run();
        logic [27:0] o;
        cfg_last  = 3'd2;
        cfg_iters = 16'd1;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (fu_op !== ctx_m[1][23:20] || imm !== ctx_m[1][15:0]) begin
            bad++;
            $display("FAIL mid_run_slot1 got op=%h imm=%h exp op=%h imm=%h",
                     fu_op, imm, ctx_m[1][23:20], ctx_m[1][15:0]);
        end
        rst = 1'b0;
        #1;
        o = {fu_en, fu_op, sel_a, sel_b, imm, busy, done, cfg_ready};
        total++;
        if (o !== {25'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset_outputs got=%h exp=%h", o, {25'd0, 3'b001});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 8; i++) ctx_m[i] = '0;
        @(posedge clk);
        #1;
        start_prog(3'd2, 16'd1, 0, 1'b0, 3'd0, 25'd0);
        wait_drain();
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mon_on = 1'b0;
        cyc_id = 0;
        test_reset();
        test_single_pass();
        test_iters3();
        test_free_run_stop();
        test_cfg_while_busy();
        test_cfg_with_start();
        test_en_zero();
        test_single_ctx();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
